flex_counter_ext: RTL and testbench
===================================

# flex_counter_ext

Parametrised, multi-mode successor to the team's basic flex counter: WIDTH-bit up/down counter with programmable rollover value, synchronous clear, parallel load and three terminal behaviours (wrap, saturate, one-shot). Used by serial-interface and timer logic that needs bit/byte counting, timeouts and periodic strobes from one block. Single clock domain; all outputs registered.

## Interface

Parameters:
- WIDTH, 4: counter width in bits (legal 2..32).

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  synchronous reset, active-high.
- clear  in  1  synchronous clear of count and status.
- count_enable  in  1  advance count by one this edge.
- dir  in  1  0 = count up, 1 = count down.
- mode  in  2  mode_t: MODE_WRAP, MODE_SAT, MODE_ONESHOT (encoding 3 treated as MODE_WRAP).
- load  in  1  load load_val this edge.
- load_val  in  WIDTH  parallel load value.
- rollover_val  in  WIDTH  upper count bound.
- count_out  out  WIDTH  current count.
- rollover_flag  out  1  high while count_out equals the terminal value.
- wrap_pulse  out  1  one-cycle pulse: a wrap occurred on the previous edge.
- done  out  1  one-shot completed; sticky until clear/load/RST.

## Operation

- Terminal value: rollover_val when dir=0; 0 when dir=1.
- Priority per edge: RST > clear > load > count_enable > hold.
- RST or clear: count_out=0, rollover_flag=0, wrap_pulse=0, done=0.
- load: count_out=load_val (no clipping), wrap_pulse=0, done=0.
- count_enable, count not at terminal: up increments, down decrements.
- Up with count_out > rollover_val (after load or rollover_val change) is treated as at terminal.
- At terminal with count_enable:
  - MODE_WRAP: up -> 0, down -> rollover_val; wrap_pulse=1 next cycle.
  - MODE_SAT: hold; no wrap_pulse.
  - MODE_ONESHOT: hold; done already set.
- MODE_ONESHOT: edge that lands count on terminal sets done=1; while done=1 count_enable ignored.
- rollover_flag registered: computed from next count against terminal using dir/rollover_val sampled at the same edge.
- rollover_val=0, up, MODE_WRAP: count stays 0, wrap_pulse every enabled cycle.
- mode/dir/rollover_val changes take effect at the next edge; no state flush.
- Arithmetic modulo 2^WIDTH never reached; comparisons unsigned.

## Timing

- All outputs registered, update on rising CLK; reset value 0 for every output.
- Count latency: count_enable at edge N -> new count_out visible after edge N.
- rollover_flag coincident with count_out reaching terminal (same cycle).
- wrap_pulse high exactly one cycle, the cycle after the wrapping edge (coincident with the wrapped count_out); back-to-back wraps give consecutive pulses.
- done rises in the same cycle count_out first equals terminal in one-shot.
- RST asserted mid-count: all outputs 0 after the next edge, regardless of other inputs.

## Structure

- flex_counter_pkg: mode_t enum (2-bit), MODE_* constants.
- One sub-module natural: flex_counter_next (combinational next-count/terminal/wrap logic), instantiated once; top holds the registers.
- No memories, no other clocks.

## Test plan

- WIDTH=4, rollover_val=5, up, MODE_WRAP, enable 7 cycles from reset -> count 1,2,3,4,5,0,1; rollover_flag high at 5; wrap_pulse high only with count 0.
- Down, rollover_val=3, MODE_WRAP, load_val=2, enable 4 cycles -> 1,0,3,2; flag at 0; wrap_pulse with 3.
- MODE_SAT up, rollover_val=9, enable 12 cycles -> holds 9, flag stays 1, wrap_pulse never asserted.
- MODE_ONESHOT up, rollover_val=4 -> done rises with count 4, further enables hold 4; clear -> count 0, done 0.
- Priority: RST, clear, load, enable asserted together -> all outputs 0; clear+load -> count 0; load=1, load_val=12 > rollover_val=5, then enable up MODE_WRAP -> count 0 with wrap_pulse.
- rollover_val=0 up MODE_WRAP, enable 3 cycles -> count 0 throughout, wrap_pulse 3 consecutive cycles.

Source files
------------

// File: rtl/flex_counter_ext_pkg.sv
// Shared types for the extended flex counter: terminal-behaviour modes.
package flex_counter_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'd0,
    MODE_SAT     = 2'd1,
    MODE_ONESHOT = 2'd2
  } mode_t;

endpackage

// File: rtl/flex_counter_ext_if.sv
// Control/status bundle for flex_counter_ext. The counter is the slave side.
interface flex_counter_ext_if #(
  parameter int WIDTH = 4
);
  import flex_counter_pkg::*;

  logic             clear;
  logic             count_enable;
  logic             dir;
  mode_t            mode;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] rollover_val;
  logic [WIDTH-1:0] count_out;
  logic             rollover_flag;
  logic             wrap_pulse;
  logic             done;

  modport master (
    output clear, count_enable, dir, mode, load, load_val, rollover_val,
    input  count_out, rollover_flag, wrap_pulse, done
  );

  modport slave (
    input  clear, count_enable, dir, mode, load, load_val, rollover_val,
    output count_out, rollover_flag, wrap_pulse, done
  );

endinterface

// File: rtl/flex_counter_ext_next.sv
// Next-state logic for flex_counter_ext: count, terminal flag, wrap and done.
module flex_counter_next
  import flex_counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] count,
  input  logic             done,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             count_enable,
  input  logic             dir,
  input  mode_t            mode,
  input  logic [WIDTH-1:0] rollover_val,
  output logic [WIDTH-1:0] count_nxt,
  output logic             flag_nxt,
  output logic             wrap_nxt,
  output logic             done_nxt
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] term;
  logic             at_term;

  // Apply clear > load > enable priority and the per-mode terminal behaviour.
  always_comb begin
    term      = dir ? '0 : rollover_val;
    // Counting up past rollover_val (after a load or bound change) is terminal.
    at_term   = dir ? (count == '0) : (count >= rollover_val);
    count_nxt = count;
    wrap_nxt  = 1'b0;
    done_nxt  = done;
    flag_nxt  = 1'b0;

    if (clear) begin
      count_nxt = '0;
      done_nxt  = 1'b0;
    end else if (load) begin
      count_nxt = load_val;
      done_nxt  = 1'b0;
    end else if (count_enable && !(mode == MODE_ONESHOT && done)) begin
      if (at_term) begin
        case (mode)
          MODE_SAT:     ;
          MODE_ONESHOT: done_nxt = 1'b1;
          default: begin
            count_nxt = dir ? rollover_val : '0;
            wrap_nxt  = 1'b1;
          end
        endcase
      end else begin
        count_nxt = dir ? (count - ONE) : (count + ONE);
        if (mode == MODE_ONESHOT && count_nxt == term) done_nxt = 1'b1;
      end
    end

    flag_nxt = !clear && (count_nxt == term);
  end

endmodule

// File: rtl/flex_counter_ext.sv
// Multi-mode WIDTH-bit up/down counter; all outputs registered.
module flex_counter_ext
  import flex_counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                CLK,
  input  logic                RST,
  flex_counter_ext_if.slave   bus
);

  logic [WIDTH-1:0] count_q, count_nxt;
  logic             flag_q, flag_nxt;
  logic             wrap_q, wrap_nxt;
  logic             done_q, done_nxt;

  flex_counter_next #(.WIDTH(WIDTH)) u_next (
    .count        (count_q),
    .done         (done_q),
    .clear        (bus.clear),
    .load         (bus.load),
    .load_val     (bus.load_val),
    .count_enable (bus.count_enable),
    .dir          (bus.dir),
    .mode         (bus.mode),
    .rollover_val (bus.rollover_val),
    .count_nxt    (count_nxt),
    .flag_nxt     (flag_nxt),
    .wrap_nxt     (wrap_nxt),
    .done_nxt     (done_nxt)
  );

  // Output registers with synchronous reset to zero.
  always_ff @(posedge CLK) begin
    if (RST) begin
      count_q <= '0;
      flag_q  <= 1'b0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_nxt;
      flag_q  <= flag_nxt;
      wrap_q  <= wrap_nxt;
      done_q  <= done_nxt;
    end
  end

  assign bus.count_out     = count_q;
  assign bus.rollover_flag = flag_q;
  assign bus.wrap_pulse    = wrap_q;
  assign bus.done          = done_q;

endmodule

// File: tb/tb_flex_counter_ext.sv
// Directed scoreboard bench for flex_counter_ext (WIDTH=4).
module tb_flex_counter_ext;
  import flex_counter_pkg::*;

  localparam int WIDTH = 4;

  typedef struct {
    string            tag;
    logic [WIDTH-1:0] cnt;
    logic             flag;
    logic             wrap;
    logic             dn;
  } exp_t;

  logic CLK = 1'b0;
  logic RST;
  int   n_cmp  = 0;
  int   n_fail = 0;
  exp_t sb[$];

  flex_counter_ext_if #(.WIDTH(WIDTH)) bus ();

  flex_counter_ext #(.WIDTH(WIDTH)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, observed=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Drive one cycle of stimulus, queue its expected result, compare after the edge.
  task automatic step(input string tag, input logic rst, input logic clr, input logic en,
                      input logic d, input mode_t m, input logic ld,
                      input logic [WIDTH-1:0] ldv, input logic [WIDTH-1:0] rv,
                      input logic [WIDTH-1:0] ec, input logic ef, input logic ew,
                      input logic ed);
    exp_t e;
    @(negedge CLK);
    RST              = rst;
    bus.clear        = clr;
    bus.count_enable = en;
    bus.dir          = d;
    bus.mode         = m;
    bus.load         = ld;
    bus.load_val     = ldv;
    bus.rollover_val = rv;
    sb.push_back('{tag, ec, ef, ew, ed});
    @(posedge CLK);
    #1;
    n_cmp++;
    assert (sb.size() == 1) else begin
      n_fail++;
      $error("FAIL %s_sb: observed=%0d expected=1 queued", tag, sb.size());
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({e.tag, "_count"}, 32'(bus.count_out), 32'(e.cnt));
      chk({e.tag, "_flag"},  32'(bus.rollover_flag), 32'(e.flag));
      chk({e.tag, "_wrap"},  32'(bus.wrap_pulse), 32'(e.wrap));
      chk({e.tag, "_done"},  32'(bus.done), 32'(e.dn));
    end
  endtask

  initial begin
    RST = 1'b1;
    bus.clear = 1'b0; bus.count_enable = 1'b0; bus.dir = 1'b0; bus.mode = MODE_WRAP;
    bus.load = 1'b0; bus.load_val = '0; bus.rollover_val = '0;

    // reset with other inputs active
    step("rst0", 1, 0, 1, 0, MODE_WRAP, 1, 4'd7, 4'd5, 4'd0, 0, 0, 0);
    step("rst1", 1, 0, 1, 0, MODE_WRAP, 0, 4'd0, 4'd5, 4'd0, 0, 0, 0);

    // up wrap, rollover 5
    step("up1", 0, 0, 1, 0, MODE_WRAP, 0, 4'd0, 4'd5, 4'd1, 0, 0, 0);
    step("up2", 0, 0, 1, 0, MODE_WRAP, 0, 4'd0, 4'd5, 4'd2, 0, 0, 0);
    step("up3", 0, 0, 1, 0, MODE_WRAP, 0, 4'd0, 4'd5, 4'd3, 0, 0, 0);
    step("up4", 0, 0, 1, 0, MODE_WRAP, 0, 4'd0, 4'd5, 4'd4, 0, 0, 0);
    step("up5", 0, 0, 1, 0, MODE_WRAP, 0, 4'd0, 4'd5, 4'd5, 1, 0, 0);
    step("up6", 0, 0, 1, 0, MODE_WRAP, 0, 4'd0, 4'd5, 4'd0, 0, 1, 0);
    step("up7", 0, 0, 1, 0, MODE_WRAP, 0, 4'd0, 4'd5, 4'd1, 0, 0, 0);

    // down wrap, rollover 3, from load 2
    step("dn_ld", 0, 0, 0, 1, MODE_WRAP, 1, 4'd2, 4'd3, 4'd2, 0, 0, 0);
    step("dn1",   0, 0, 1, 1, MODE_WRAP, 0, 4'd0, 4'd3, 4'd1, 0, 0, 0);
    step("dn2",   0, 0, 1, 1, MODE_WRAP, 0, 4'd0, 4'd3, 4'd0, 1, 0, 0);
    step("dn3",   0, 0, 1, 1, MODE_WRAP, 0, 4'd0, 4'd3, 4'd3, 0, 1, 0);
    step("dn4",   0, 0, 1, 1, MODE_WRAP, 0, 4'd0, 4'd3, 4'd2, 0, 0, 0);

    // saturate up at 9
    step("sat_clr", 0, 1, 0, 0, MODE_SAT, 0, 4'd0, 4'd9, 4'd0, 0, 0, 0);
    for (int i = 1; i <= 12; i++) begin
      if (i < 9) step($sformatf("sat%0d", i), 0, 0, 1, 0, MODE_SAT, 0, 4'd0, 4'd9, 4'(i), 0, 0, 0);
      else       step($sformatf("sat%0d", i), 0, 0, 1, 0, MODE_SAT, 0, 4'd0, 4'd9, 4'd9, 1, 0, 0);
    end

    // one-shot up to 4
    step("os_clr", 0, 1, 0, 0, MODE_ONESHOT, 0, 4'd0, 4'd4, 4'd0, 0, 0, 0);
    step("os1",    0, 0, 1, 0, MODE_ONESHOT, 0, 4'd0, 4'd4, 4'd1, 0, 0, 0);
    step("os2",    0, 0, 1, 0, MODE_ONESHOT, 0, 4'd0, 4'd4, 4'd2, 0, 0, 0);
    step("os3",    0, 0, 1, 0, MODE_ONESHOT, 0, 4'd0, 4'd4, 4'd3, 0, 0, 0);
    step("os4",    0, 0, 1, 0, MODE_ONESHOT, 0, 4'd0, 4'd4, 4'd4, 1, 0, 1);
    step("os5",    0, 0, 1, 0, MODE_ONESHOT, 0, 4'd0, 4'd4, 4'd4, 1, 0, 1);
    step("os6",    0, 0, 1, 0, MODE_ONESHOT, 0, 4'd0, 4'd4, 4'd4, 1, 0, 1);
    step("os_c2",  0, 1, 1, 0, MODE_ONESHOT, 0, 4'd0, 4'd4, 4'd0, 0, 0, 0);

    // priority checks
    step("pr_ld7",  0, 0, 0, 0, MODE_WRAP, 1, 4'd7,  4'd5, 4'd7,  0, 0, 0);
    step("pr_all",  1, 1, 1, 0, MODE_WRAP, 1, 4'd3,  4'd5, 4'd0,  0, 0, 0);
    step("pr_ld3",  0, 0, 1, 0, MODE_WRAP, 1, 4'd3,  4'd5, 4'd3,  0, 0, 0);
    step("pr_clld", 0, 1, 1, 0, MODE_WRAP, 1, 4'd9,  4'd5, 4'd0,  0, 0, 0);
    step("pr_ld12", 0, 0, 0, 0, MODE_WRAP, 1, 4'd12, 4'd5, 4'd12, 0, 0, 0);
    step("pr_over", 0, 0, 1, 0, MODE_WRAP, 0, 4'd0,  4'd5, 4'd0,  0, 1, 0);

    // rollover_val 0: back-to-back wraps, then idle drops the pulse
    step("rv0_1",  0, 0, 1, 0, MODE_WRAP, 0, 4'd0, 4'd0, 4'd0, 1, 1, 0);
    step("rv0_2",  0, 0, 1, 0, MODE_WRAP, 0, 4'd0, 4'd0, 4'd0, 1, 1, 0);
    step("rv0_3",  0, 0, 1, 0, MODE_WRAP, 0, 4'd0, 4'd0, 4'd0, 1, 1, 0);
    step("rv0_id", 0, 0, 0, 0, MODE_WRAP, 0, 4'd0, 4'd0, 4'd0, 1, 0, 0);

    // mode encoding 3 behaves as wrap
    step("m3_1", 0, 0, 1, 0, mode_t'(2'd3), 0, 4'd0, 4'd1, 4'd1, 1, 0, 0);
    step("m3_2", 0, 0, 1, 0, mode_t'(2'd3), 0, 4'd0, 4'd1, 4'd0, 0, 1, 0);

    // mid-count reset
    step("mr_1",  0, 0, 1, 0, MODE_WRAP, 0, 4'd0, 4'd9, 4'd1, 0, 0, 0);
    step("mr_rst", 1, 0, 1, 0, MODE_WRAP, 1, 4'd6, 4'd9, 4'd0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
